// File: rtl/fdc_dma_fifo.sv
// Sector data buffer between the floppy disk byte stream and the ISA bus.
// The host side is served by PIO through the DATA port or by 8237 DMA (drq/dack_n/tc).
// The disk side is a valid/ready byte stream whose direction follows CTRL.DIR.
module fdc_dma_fifo #(
    parameter int          DEPTH = 16,
    parameter int          AW    = 4,
    parameter logic [9:0]  BASE  = 10'h3F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] a,
    input  logic        aen,
    input  logic        ior_n,
    input  logic        iow_n,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic        drq,
    input  logic        dack_n,
    input  logic        tc,
    output logic        irq,
    input  logic [7:0]  dsk_wdata,
    input  logic        dsk_wvalid,
    output logic        dsk_wready,
    output logic [7:0]  dsk_rdata,
    output logic        dsk_rvalid,
    input  logic        dsk_rready
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    ctrl;
    logic          done, err;
    logic          ior_q, iow_q;

    logic en, dir, dmaen, irqen;
    logic empty, full;
    logic rd_edge, wr_edge, dma_acc, pio_ok;
    logic hit_ctrl, hit_stat, hit_data, data_sel;
    logic bus_rd_data, bus_wr_data, bus_pop, bus_push;
    logic dsk_push, dsk_pop, push, pop;
    logic ctrl_wr, flush, err_set, done_set, drq_next;
    logic [7:0] status, push_data;
    logic unused_addr;

    assign unused_addr = ^a[19:10];

    assign en    = ctrl[0];
    assign dir   = ctrl[1];
    assign dmaen = ctrl[2];
    assign irqen = ctrl[3];

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Decode strobes, addresses and FIFO push/pop requests for this cycle
    always_comb begin
        rd_edge  = ~ior_n & ior_q;
        wr_edge  = ~iow_n & iow_q;
        dma_acc  = ~dack_n;
        pio_ok   = ~aen & dack_n;
        hit_ctrl = pio_ok & (a[9:0] == BASE);
        hit_stat = pio_ok & (a[9:0] == BASE + 10'd1);
        hit_data = pio_ok & (a[9:0] == BASE + 10'd2);
        data_sel = hit_data | dma_acc;

        bus_rd_data = rd_edge & data_sel;
        bus_wr_data = wr_edge & data_sel;
        bus_pop     = bus_rd_data & en & ~dir & ~empty;
        bus_push    = bus_wr_data & en & dir & ~full;

        dsk_wready = en & ~dir & ~full;
        dsk_rvalid = en & dir & ~empty;
        dsk_push   = dsk_wvalid & dsk_wready;
        dsk_pop    = dsk_rvalid & dsk_rready;

        push      = bus_push | dsk_push;
        pop       = bus_pop | dsk_pop;
        push_data = dir ? d_in : dsk_wdata;

        ctrl_wr  = wr_edge & hit_ctrl;
        flush    = ctrl_wr & (d_in[4] | (d_in[1] != dir));
        err_set  = (bus_rd_data & en & ~dir & empty) | (bus_wr_data & en & dir & full);
        done_set = dma_acc & (rd_edge | wr_edge) & tc;

        status = {4'(count), err, done, full, empty};

        // A DMA strobe drops drq for one clk so the 8237 re-arbitrates
        drq_next = en & dmaen & ~done & (dir ? ~full : ~empty)
                   & ~(dma_acc & (rd_edge | wr_edge));

        d_oe      = ~ior_n & (hit_ctrl | hit_stat | hit_data | dma_acc);
        dsk_rdata = mem[rd_ptr];
    end

    // FIFO storage; a flush discards any push landing in the same cycle
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Control, pointers, flags, read data and request outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ior_q  <= 1'b0;
            iow_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ctrl   <= 4'h0;
            done   <= 1'b0;
            err    <= 1'b0;
            drq    <= 1'b0;
            irq    <= 1'b0;
            d_out  <= 8'h00;
        end else begin
            ior_q <= ior_n;
            iow_q <= iow_n;
            drq   <= drq_next;
            irq   <= irqen & done;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)      count <= count + (AW+1)'(1);
                else if (pop && !push) count <= count - (AW+1)'(1);
            end

            if (ctrl_wr) ctrl <= d_in[3:0];

            if (flush || (rd_edge && hit_stat)) begin
                done <= 1'b0;
                err  <= 1'b0;
            end else begin
                if (err_set)  err  <= 1'b1;
                if (done_set) done <= 1'b1;
            end

            if (rd_edge) begin
                if (hit_ctrl)      d_out <= {4'h0, ctrl};
                else if (hit_stat) d_out <= status;
                else if (data_sel) d_out <= bus_pop ? mem[rd_ptr] : 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_fdc_dma_fifo.sv
// Directed testbench for fdc_dma_fifo: PIO, disk stream, DMA, wrap, flush and reset cases.
module tb_fdc_dma_fifo;

    localparam logic [9:0] CTRL = 10'h3F0;
    localparam logic [9:0] STAT = 10'h3F1;
    localparam logic [9:0] DATA = 10'h3F2;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] a;
    logic        aen, ior_n, iow_n;
    logic [7:0]  d_in, d_out;
    logic        d_oe, drq, dack_n, tc, irq;
    logic [7:0]  dsk_wdata, dsk_rdata;
    logic        dsk_wvalid, dsk_wready, dsk_rvalid, dsk_rready;

    int checks = 0;
    int errors = 0;

    fdc_dma_fifo dut (
        .clk(clk), .rst(rst), .a(a), .aen(aen), .ior_n(ior_n), .iow_n(iow_n),
        .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .drq(drq), .dack_n(dack_n),
        .tc(tc), .irq(irq), .dsk_wdata(dsk_wdata), .dsk_wvalid(dsk_wvalid),
        .dsk_wready(dsk_wready), .dsk_rdata(dsk_rdata), .dsk_rvalid(dsk_rvalid),
        .dsk_rready(dsk_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pio_read(input logic [9:0] adr, output logic [7:0] data);
        @(negedge clk);
        a = {10'h000, adr};
        aen = 1'b0;
        ior_n = 1'b0;
        @(negedge clk);
        data = d_out;
        ior_n = 1'b1;
    endtask

    task automatic pio_write(input logic [9:0] adr, input logic [7:0] val);
        @(negedge clk);
        a = {10'h000, adr};
        aen = 1'b0;
        d_in = val;
        iow_n = 1'b0;
        @(negedge clk);
        iow_n = 1'b1;
    endtask

    task automatic read_chk(input string tag, input logic [9:0] adr, input logic [7:0] exp);
        logic [7:0] v;
        pio_read(adr, v);
        chk(tag, v, exp);
    endtask

    task automatic disk_push(input logic [7:0] val);
        @(negedge clk);
        dsk_wdata = val;
        dsk_wvalid = 1'b1;
        chk("dsk_wready", dsk_wready, 8'h01);
        @(negedge clk);
        dsk_wvalid = 1'b0;
    endtask

    task automatic drain_one(input logic [7:0] exp);
        @(negedge clk);
        chk("dsk_rvalid", dsk_rvalid, 8'h01);
        chk("dsk_rdata", dsk_rdata, exp);
        dsk_rready = 1'b1;
        @(negedge clk);
        dsk_rready = 1'b0;
    endtask

    task automatic wait_drq(output logic got);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (drq) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        logic got;

        rst = 1'b1; a = '0; aen = 1'b0; ior_n = 1'b1; iow_n = 1'b1; d_in = '0;
        dack_n = 1'b1; tc = 1'b0; dsk_wdata = '0; dsk_wvalid = 1'b0; dsk_rready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_drq", drq, 8'h00);
        chk("rst_irq", irq, 8'h00);
        chk("rst_wready", dsk_wready, 8'h00);
        chk("rst_rvalid", dsk_rvalid, 8'h00);
        chk("rst_doe", d_oe, 8'h00);
        chk("rst_dout", d_out, 8'h00);
        read_chk("rst_status", STAT, 8'h01);

        // PIO read of 5 disk bytes, then underflow
        pio_write(CTRL, 8'h01);
        for (int i = 0; i < 5; i++) disk_push(8'hA0 + 8'(i));
        read_chk("pio_status5", STAT, 8'h50);
        for (int i = 0; i < 5; i++) read_chk("pio_data", DATA, 8'hA0 + 8'(i));
        read_chk("pio_underflow", DATA, 8'hFF);
        read_chk("pio_err", STAT, 8'h09);
        read_chk("pio_err_clr", STAT, 8'h01);

        // Host->disk: fill, overflow, drain, three rounds
        pio_write(CTRL, 8'h03);
        read_chk("ctrl_rb", CTRL, 8'h03);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) pio_write(DATA, 8'(i));
            read_chk("full_status", STAT, 8'h02);
            pio_write(DATA, 8'hEE);
            read_chk("overflow_err", STAT, 8'h0A);
            for (int i = 0; i < 16; i++) drain_one(8'(i));
            read_chk("drained", STAT, 8'h01);
        end
        read_chk("wrong_dir_rd", DATA, 8'hFF);
        read_chk("wrong_dir_noerr", STAT, 8'h01);

        // DMA read of 512 bytes with tc on the last one
        pio_write(CTRL, 8'h0D);
        for (int i = 0; i < 512; i++) begin
            disk_push(i[7:0]);
            wait_drq(got);
            chk("dma_drq_up", got, 8'h01);
            dack_n = 1'b0; ior_n = 1'b0; aen = 1'b1; a = 20'hFFFFF; tc = (i == 511);
            @(negedge clk);
            chk("dma_doe", d_oe, 8'h01);
            v = d_out;
            chk("dma_drq_gap", drq, 8'h00);
            dack_n = 1'b1; ior_n = 1'b1; aen = 1'b0; tc = 1'b0;
            chk("dma_data", v, i[7:0]);
        end
        chk("tc_irq_lat", irq, 8'h00);
        @(negedge clk);
        chk("tc_irq", irq, 8'h01);
        chk("tc_drq", drq, 8'h00);
        repeat (3) @(negedge clk);
        chk("tc_drq_hold", drq, 8'h00);
        read_chk("tc_status", STAT, 8'h05);
        @(negedge clk);
        chk("irq_clr", irq, 8'h00);

        // Simultaneous push and pop at count 8, then flushes
        pio_write(CTRL, 8'h01);
        for (int i = 0; i < 8; i++) disk_push(8'h10 + 8'(i));
        read_chk("sim_status8", STAT, 8'h80);
        @(negedge clk);
        a = {10'h000, DATA}; aen = 1'b0; ior_n = 1'b0;
        dsk_wdata = 8'h18; dsk_wvalid = 1'b1;
        @(negedge clk);
        v = d_out;
        ior_n = 1'b1; dsk_wvalid = 1'b0;
        chk("sim_pop", v, 8'h10);
        read_chk("sim_count", STAT, 8'h80);
        read_chk("sim_next", DATA, 8'h11);
        read_chk("sim_count7", STAT, 8'h70);
        pio_write(CTRL, 8'h03);
        read_chk("dir_flip", STAT, 8'h01);
        pio_write(DATA, 8'h55);
        pio_write(DATA, 8'h66);
        read_chk("pre_flush", STAT, 8'h20);
        pio_write(CTRL, 8'h13);
        read_chk("flush_status", STAT, 8'h01);
        read_chk("flush_rb", CTRL, 8'h03);

        // Reset during a DMA burst
        pio_write(CTRL, 8'h0D);
        for (int i = 0; i < 3; i++) disk_push(8'hC0 + 8'(i));
        wait_drq(got);
        chk("burst_drq", got, 8'h01);
        dack_n = 1'b0; ior_n = 1'b0; aen = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_drq", drq, 8'h00);
        chk("mid_rst_irq", irq, 8'h00);
        chk("mid_rst_dout", d_out, 8'h00);
        chk("mid_rst_wready", dsk_wready, 8'h00);
        chk("mid_rst_rvalid", dsk_rvalid, 8'h00);
        dack_n = 1'b1; ior_n = 1'b1; aen = 1'b0;
        @(negedge clk);
        chk("mid_rst_doe", d_oe, 8'h00);
        rst = 1'b0;
        read_chk("post_rst_status", STAT, 8'h01);
        read_chk("post_rst_ctrl", CTRL, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
